bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/seq_pkg.sv | 25 ++
 rtl/bit_timer.sv | 40 ++++
 rtl/bit_serializer.sv | 168 ++++++++++++++++
 tb/tb_bit_serializer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared types and constants for the serializer / sequence
//               detector slice: serializer FSM state encoding, parameter
//               defaults, and the 12-bit pattern the detector looks for.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

    localparam int   c_DEF_WIDTH    = 12;
    localparam int   c_DEF_HOLD     = 2;
    localparam int   c_DEF_GAP      = 4;
    localparam logic c_DEF_IDLE_LVL = 1'b0;

    localparam logic [11:0] DETECT_PATTERN = 12'b0000_0111_0100;

endpackage : seq_pkg
`default_nettype wire

// File: rtl/bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : bit_timer
// Description : HOLD-cycle prescaler. While en is high, hold_cnt counts
//               0..HOLD-1 and wraps; tick is high on the HOLD-1 count, which
//               marks the last clock of each bit period. While en is low the
//               counter sits at 0, so a new period always starts aligned.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous reset, active high
//               en   - count enable (serializer busy)
//               tick - last cycle of the current bit period
// Revision    : 1.0 - initial release
// ============================================================================
module bit_timer #(
    parameter int HOLD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [3:0] c_HOLD_LAST = 4'(HOLD - 1);

    logic [3:0] r_hold_cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_hold_cnt <= 4'd0;
        end else if (r_hold_cnt == c_HOLD_LAST) begin
            r_hold_cnt <= 4'd0;
        end else begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
        end
    end

    assign tick = en && (r_hold_cnt == c_HOLD_LAST);

endmodule : bit_timer
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer
// Description : Parallel-to-serial converter with one frame of look-ahead
//               buffering. Frames are sent MSB first, each bit held HOLD
//               clocks, followed by GAP idle bit-periods. A frame accepted
//               while a frame is in flight waits in a single pending
//               register and starts immediately after the current gap.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous reset, active high
//               din        - parallel frame (WIDTH bits)
//               din_valid  - din holds a valid frame
//               din_ready  - frame can be accepted this cycle
//               ser_out    - registered serial output
//               busy       - high in SHIFT or GAP
//               frame_done - pulse on the last hold cycle of bit 0
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH    = c_DEF_WIDTH,
    parameter int   HOLD     = c_DEF_HOLD,
    parameter int   GAP      = c_DEF_GAP,
    parameter logic IDLE_LVL = c_DEF_IDLE_LVL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             busy,
    output logic             frame_done
);

    localparam int              c_BW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(WIDTH - 1);
    localparam logic [3:0]      c_GAP_LAST  = 4'((GAP > 0) ? (GAP - 1) : 0);

    ser_state_t       r_state,      w_state;
    logic [WIDTH-1:0] r_shift,      w_shift;
    logic [WIDTH-1:0] r_pend,       w_pend;
    logic             r_pend_valid, w_pend_valid;
    logic [c_BW-1:0]  r_bit,        w_bit;
    logic [3:0]       r_gap,        w_gap;
    logic             r_ser;

    logic w_tick;
    logic w_accept;
    logic w_leave;
    logic w_done;
    logic w_ser_next;

    bit_timer #(
        .HOLD (HOLD)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (r_state != IDLE),
        .tick (w_tick)
    );

    assign din_ready = !r_pend_valid && !rst;
    assign w_accept  = din_valid && din_ready;

    always_comb begin
        w_state      = r_state;
        w_shift      = r_shift;
        w_pend       = r_pend;
        w_pend_valid = r_pend_valid;
        w_bit        = r_bit;
        w_gap        = r_gap;
        w_leave      = 1'b0;
        w_done       = 1'b0;

        // Any frame offered while a frame is in flight parks in pending;
        // din_ready guarantees pending is empty when this happens.
        if (w_accept && (r_state != IDLE)) begin
            w_pend       = din;
            w_pend_valid = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (r_pend_valid) begin
                    w_shift      = r_pend;
                    w_pend_valid = 1'b0;
                    w_state      = SHIFT;
                end else if (w_accept) begin
                    // Bypass pending so the first bit appears next cycle.
                    w_shift = din;
                    w_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_tick) begin
                    if (r_bit == c_BIT_LAST) begin
                        w_bit  = '0;
                        w_done = 1'b1;
                        if (GAP != 0) begin
                            w_state = seq_pkg::GAP;
                        end else begin
                            w_leave = 1'b1;
                        end
                    end else begin
                        w_bit   = r_bit + 1'b1;
                        w_shift = r_shift << 1;
                    end
                end
            end
            seq_pkg::GAP: begin
                if (w_tick) begin
                    if (r_gap == c_GAP_LAST) begin
                        w_gap   = 4'd0;
                        w_leave = 1'b1;
                    end else begin
                        w_gap = r_gap + 4'd1;
                    end
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        // End of frame+gap: chain straight into a pending frame so the line
        // never shows an extra idle cycle between buffered frames.
        if (w_leave) begin
            if (r_pend_valid) begin
                w_shift      = r_pend;
                w_pend_valid = 1'b0;
                w_state      = SHIFT;
            end else begin
                w_state = IDLE;
            end
        end
    end

    // Output bit is computed from next state so ser_out is a clean flop.
    assign w_ser_next = (w_state == SHIFT) ? w_shift[WIDTH-1] : IDLE_LVL;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_bit        <= '0;
            r_gap        <= 4'd0;
            r_ser        <= IDLE_LVL;
        end else begin
            r_state      <= w_state;
            r_shift      <= w_shift;
            r_pend       <= w_pend;
            r_pend_valid <= w_pend_valid;
            r_bit        <= w_bit;
            r_gap        <= w_gap;
            r_ser        <= w_ser_next;
        end
    end

    assign ser_out    = r_ser;
    assign busy       = (r_state != IDLE);
    assign frame_done = w_done;

endmodule : bit_serializer
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serializer
// Description : Directed self-checking bench for bit_serializer. One instance
//               uses the default parameters, a second uses HOLD=1, GAP=0 for
//               the back-to-back streaming case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        ser_out;
    logic        busy;
    logic        frame_done;

    logic [11:0] din2;
    logic        din_valid2;
    logic        din_ready2;
    logic        ser_out2;
    logic        busy2;
    logic        frame_done2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    bit_serializer u_dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .ser_out    (ser_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    bit_serializer #(
        .HOLD (1),
        .GAP  (0)
    ) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .din        (din2),
        .din_valid  (din_valid2),
        .din_ready  (din_ready2),
        .ser_out    (ser_out2),
        .busy       (busy2),
        .frame_done (frame_done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are then examined 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] fa, fb, fc, win;
        logic [11:0] f5 [5];
        logic        exp_ser, bad, acc;
        int          dcount, acc_cycle, fi;

        rst        = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        din2       = '0;
        din_valid2 = 1'b0;
        step();
        step();

        // ---------------- reset state ----------------
        chk("rst_ser",    ser_out,    1'b0);
        chk("rst_busy",   busy,       1'b0);
        chk("rst_done",   frame_done, 1'b0);
        chk("rst_ready",  din_ready,  1'b0);
        chk("rst_ready2", din_ready2, 1'b0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", din_ready, 1'b1);

        // ---------------- S1: single frame 0x074 ----------------
        fa        = seq_pkg::DETECT_PATTERN;
        din       = fa;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        din       = '0;
        win       = '0;
        dcount    = 0;
        for (int c = 1; c <= 32; c++) begin
            exp_ser = (c <= 24) ? fa[11-(c-1)/2] : 1'b0;
            chk($sformatf("s1_ser_c%0d", c),  ser_out,    exp_ser);
            chk($sformatf("s1_done_c%0d", c), frame_done, (c == 24));
            chk($sformatf("s1_busy_c%0d", c), busy,       1'b1);
            if ((c - 1) % 2 == 0) begin
                win = {win[10:0], ser_out};
                if (win == seq_pkg::DETECT_PATTERN) dcount++;
            end
            step();
        end
        chk("s1_idle_busy",  busy,      1'b0);
        chk("s1_idle_ready", din_ready, 1'b1);
        chk("s1_detect_cnt", dcount,    1);

        // ---------------- S2: A then B offered at cycle 3 ----------------
        fa        = 12'hA5C;
        fb        = 12'h3C9;
        din       = fa;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int c = 1; c <= 65; c++) begin
            if (c <= 24)                 exp_ser = fa[11-(c-1)/2];
            else if (c >= 33 && c <= 56) exp_ser = fb[11-(c-33)/2];
            else                         exp_ser = 1'b0;
            chk($sformatf("s2_ser_c%0d", c),  ser_out,    exp_ser);
            chk($sformatf("s2_done_c%0d", c), frame_done, (c == 24 || c == 56));
            if (c >= 4 && c <= 32) chk($sformatf("s2_ready_c%0d", c), din_ready, 1'b0);
            if (c == 33)           chk("s2_ready_c33", din_ready, 1'b1);
            if (c == 65)           chk("s2_busy_c65",  busy,      1'b0);
            if (c == 3) begin
                chk("s2_ready_c3", din_ready, 1'b1);
                din       = fb;
                din_valid = 1'b1;
            end
            step();
            if (c == 3) din_valid = 1'b0;
        end

        // ---------------- S3: third frame held while pending full ----------------
        fa        = 12'h0F1;
        fb        = 12'hE38;
        fc        = 12'h5B6;
        acc_cycle = -1;
        din       = fa;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int c = 1; c <= 97; c++) begin
            if (c <= 24)                 exp_ser = fa[11-(c-1)/2];
            else if (c >= 33 && c <= 56) exp_ser = fb[11-(c-33)/2];
            else if (c >= 65 && c <= 88) exp_ser = fc[11-(c-65)/2];
            else                         exp_ser = 1'b0;
            chk($sformatf("s3_ser_c%0d", c),   ser_out,    exp_ser);
            chk($sformatf("s3_done_c%0d", c),  frame_done, (c == 24 || c == 56 || c == 88));
            chk($sformatf("s3_ready_c%0d", c), din_ready,
                (c == 1 || c == 33 || c >= 65));
            if (c == 1) begin
                din       = fb;
                din_valid = 1'b1;
            end
            if (c == 2) begin
                din       = fc;
                din_valid = 1'b1;
            end
            acc = din_valid && din_ready;
            if (c >= 2 && acc) acc_cycle = c;
            step();
            if (c == 1 || acc) din_valid = 1'b0;
        end
        chk("s3_c_accept_cycle", acc_cycle, 33);
        chk("s3_final_busy",     busy,      1'b0);

        // ---------------- S4: reset mid-frame with pending full ----------------
        din       = 12'hFFF;
        din_valid = 1'b1;
        step();
        din       = 12'hABC;
        step();
        din_valid = 1'b0;
        for (int c = 2; c <= 9; c++) step();
        chk("s4_busy_pre", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("s4_ready_in_rst", din_ready, 1'b0);
        step();
        chk("s4_ser_after",   ser_out,    1'b0);
        chk("s4_busy_after",  busy,       1'b0);
        chk("s4_done_after",  frame_done, 1'b0);
        chk("s4_ready_after", din_ready,  1'b0);
        rst = 1'b0;
        #1;
        chk("s4_ready_rst_fall", din_ready, 1'b1);
        bad = 1'b0;
        for (int c = 0; c < 70; c++) begin
            if (ser_out !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) bad = 1'b1;
            step();
        end
        chk("s4_pending_dropped", bad, 1'b0);

        // ---------------- S5: HOLD=1 GAP=0 continuous valid ----------------
        f5[0] = 12'h074;
        f5[1] = 12'hFFF;
        f5[2] = 12'h801;
        f5[3] = 12'hA5A;
        f5[4] = 12'h5A5;
        fi    = 0;
        for (int c = 0; c <= 48; c++) begin
            if (c >= 1) begin
                fc = f5[(c-1)/12];
                chk($sformatf("s5_ser_c%0d", c),  ser_out2,    fc[11-(c-1)%12]);
                chk($sformatf("s5_done_c%0d", c), frame_done2, ((c % 12) == 0));
                chk($sformatf("s5_busy_c%0d", c), busy2,       1'b1);
            end
            din2       = f5[fi % 5];
            din_valid2 = 1'b1;
            acc        = din_ready2;
            step();
            if (acc) fi++;
        end
        din_valid2 = 1'b0;
        chk("s5_accepted", fi, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_bit_serializer
`default_nettype wire
